// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [2:0]       mdu_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, b_mag;
   logic             is_mul, neg_q, neg_r, divz;

   logic             op_mul, op_div, op_sgn, accept, launch, last;
   logic [WIDTH-1:0] a_in, b_in;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Valid/ready contract: a request is taken on any edge where start=1 and the unit
   // is not in RUN; there is no backpressure beyond busy, and done marks HI/LO update.
   always_comb begin
      op_mul = (mdu_op == 3'b001) || (mdu_op == 3'b010);
      op_div = (mdu_op == 3'b011) || (mdu_op == 3'b100);
      op_sgn = (mdu_op == 3'b001) || (mdu_op == 3'b011);
      accept = start && (state != RUN);
      launch = accept && (op_mul || op_div);
      last   = (state == RUN) && (cnt == CW'(1));
      a_in   = (op_sgn && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
      b_in   = (op_sgn && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;
   end

   // One iteration of either algorithm on the shared accumulator pair.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
      div_sh   = {acc_hi, acc_lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_mag};
      div_ge   = (div_sh >= {1'b0, b_mag});
      if (is_mul) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else begin
         step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], div_ge};
      end
      prod     = {step_hi, step_lo};
      prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - prod) : prod;
      // A zero divisor leaves the remainder equal to the dividend, so only LO needs forcing.
      quo_fix  = divz ? {WIDTH{1'b1}} : (neg_q ? ({WIDTH{1'b0}} - step_lo) : step_lo);
      rem_fix  = neg_r ? ({WIDTH{1'b0}} - step_hi) : step_hi;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = launch ? RUN : IDLE;
         RUN:     state_nxt = last ? FIN : RUN;
         FIN:     state_nxt = launch ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         b_mag  <= '0;
         is_mul <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         divz   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            acc_hi <= '0;
            acc_lo <= a_in;
            b_mag  <= b_in;
            is_mul <= op_mul;
            neg_q  <= op_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= op_sgn && A[WIDTH-1];
            divz   <= op_div && (B == '0);
            cnt    <= CW'(WIDTH);
         end else if (accept && mdu_op == 3'b101) begin
            hi <= A;
         end else if (accept && mdu_op == 3'b110) begin
            lo <= A;
         end
         if (state == RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CW'(1);
            if (last) begin
               if (is_mul) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == FIN);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: reset, HI/LO moves, multiply/divide corners,
// busy-time request rejection and reset abort.
module tb_mdu_iter;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [2:0]  mdu_op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   int bc, dc, da;
   logic [31:0] mid_hi, mid_lo;

   mdu_iter #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .start(start), .mdu_op(mdu_op),
      .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, then watch 40 cycles. bc counts busy cycles, dc done pulses,
   // da the cycle index (after start edge = 0) of the first done. mode 1 injects a
   // DIV request at cycle 10; mode 2 pulls reset at cycle 15.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode);
      @(negedge clk);
      start = 1'b1; mdu_op = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0; mdu_op = 3'b000;
      bc = 0; dc = 0; da = -1;
      for (int i = 0; i < 40; i++) begin
         if (busy) bc++;
         if (done) begin
            dc++;
            if (da < 0) da = i;
         end
         if (i == 16) begin
            mid_hi = hi;
            mid_lo = lo;
         end
         if (mode == 1 && i == 10) begin
            start = 1'b1; mdu_op = 3'b011; A = 32'd9; B = 32'd3;
         end
         if (mode == 1 && i == 11) begin
            start = 1'b0; mdu_op = 3'b000;
         end
         if (mode == 2 && i == 15) rstn = 1'b0;
         if (mode == 2 && i == 17) rstn = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic check_iter(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_busy_cycles"}, 32'(bc), 32'd32);
      check({tag, "_done_pulses"}, 32'(dc), 32'd1);
      check({tag, "_done_cycle"}, 32'(da), 32'd32);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; mdu_op = 3'b000; A = '0; B = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      rstn = 1'b1;

      @(negedge clk);
      start = 1'b1; mdu_op = 3'b101; A = 32'h12345678;
      @(negedge clk);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_busy", {31'b0, busy}, 32'd0);
      mdu_op = 3'b110; A = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0; mdu_op = 3'b000;
      check("mtlo_lo", lo, 32'h9ABCDEF0);
      check("mtlo_hi_kept", hi, 32'h12345678);
      check("mtlo_busy", {31'b0, busy}, 32'd0);
      check("mtlo_done", {31'b0, done}, 32'd0);

      run_op(3'b001, 32'hFFFFFFFD, 32'd5, 0);
      check("mult_mid_hi_hold", mid_hi, 32'h12345678);
      check("mult_mid_lo_hold", mid_lo, 32'h9ABCDEF0);
      check_iter("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);

      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      check_iter("multu_max", 32'hFFFFFFFE, 32'h00000001);

      run_op(3'b011, 32'hFFFFFFF9, 32'd2, 0);
      check_iter("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD);

      run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 0);
      check_iter("div_ovf", 32'h00000000, 32'h80000000);

      run_op(3'b100, 32'd7, 32'd0, 0);
      check_iter("divu_by0", 32'd7, 32'hFFFFFFFF);

      run_op(3'b011, 32'hFFFFFFF9, 32'd0, 0);
      check_iter("div_neg_by0", 32'hFFFFFFF9, 32'hFFFFFFFF);

      run_op(3'b100, 32'd100, 32'd7, 0);
      check_iter("divu_100d7", 32'd2, 32'd14);

      run_op(3'b010, 32'd3, 32'd4, 1);
      check_iter("multu_busy_ignore", 32'd0, 32'd12);

      run_op(3'b100, 32'd100, 32'd7, 2);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_busy_cycles", 32'(bc), 32'd16);
      check("abort_done_pulses", 32'(dc), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
